// File: rtl/cd_rx_drain.sv
// cd_rx_drain: on cdbus irq, confirms RX pending, streams the RX RAM frame out byte by byte, then releases the page.
// Optional sink-stall abort is compiled in with `define CD_RX_DRAIN_TIMEOUT_EN.
module cd_rx_drain #(
    parameter logic [3:0]  REG_STATUS  = 4'd0,
    parameter logic [3:0]  REG_RX_CTRL = 4'd5,
    parameter int          BIT_RX_PEND = 2,
    parameter int          BIT_RD_DONE = 0,
    parameter logic [15:0] TIMEOUT     = 16'd4096
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        irq,
    output logic [3:0]  csr_address,
    output logic [3:0]  csr_byteenable,
    output logic        csr_read,
    input  logic [31:0] csr_readdata,
    output logic        csr_write,
    output logic [31:0] csr_writedata,
    output logic [5:0]  rx_mm_address,
    output logic        rx_mm_read,
    input  logic [31:0] rx_mm_readdata,
    output logic [7:0]  m_data,
    output logic        m_valid,
    output logic        m_last,
    input  logic        m_ready,
    output logic        busy,
    output logic [15:0] frame_cnt,
    output logic [15:0] drop_cnt
);

    typedef enum logic [2:0] {IDLE, ST_RD, ST_CHK, W_RD, W_WAIT, STREAM, REL} state_t;

    state_t      state_q, state_d;
    logic [7:0]  idx_q, idx_d;
    logic [8:0]  total_q, total_d;
    logic [31:0] buf_q, buf_d;
    logic [15:0] frame_q, frame_d;
    logic [7:0]  len_clamped;
    logic        last_byte;

`ifdef CD_RX_DRAIN_TIMEOUT_EN
    logic [15:0] stall_q, stall_d;
    logic [15:0] drop_q, drop_d;
    logic        abort_q, abort_d;
`endif

    // Length byte is clamped so a frame never exceeds the 256-byte page.
    assign len_clamped    = (rx_mm_readdata[23:16] > 8'd253) ? 8'd253 : rx_mm_readdata[23:16];
    assign last_byte      = (({1'b0, idx_q} + 9'd1) == total_q);
    assign csr_byteenable = 4'b1111;
    assign rx_mm_address  = idx_q[7:2];
    assign busy           = (state_q != IDLE);
    assign frame_cnt      = frame_q;

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        total_d       = total_q;
        buf_d         = buf_q;
        frame_d       = frame_q;
        csr_read      = 1'b0;
        csr_write     = 1'b0;
        csr_address   = 4'd0;
        csr_writedata = 32'd0;
        rx_mm_read    = 1'b0;
        m_valid       = 1'b0;
        m_last        = 1'b0;
        m_data        = 8'd0;
`ifdef CD_RX_DRAIN_TIMEOUT_EN
        stall_d       = stall_q;
        drop_d        = drop_q;
        abort_d       = abort_q;
`endif
        case (state_q)
            IDLE: begin
                if (enable && irq) state_d = ST_RD;
            end
            ST_RD: begin
                csr_read    = 1'b1;
                csr_address = REG_STATUS;
                state_d     = ST_CHK;
            end
            ST_CHK: begin
                if (csr_readdata[BIT_RX_PEND]) begin
                    idx_d   = 8'd0;
                    state_d = W_RD;
`ifdef CD_RX_DRAIN_TIMEOUT_EN
                    abort_d = 1'b0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            W_RD: begin
                rx_mm_read = 1'b1;
                state_d    = W_WAIT;
            end
            W_WAIT: begin
                buf_d = rx_mm_readdata;
                if (idx_q == 8'd0) total_d = 9'd3 + {1'b0, len_clamped};
                state_d = STREAM;
            end
            STREAM: begin
                m_valid = 1'b1;
                m_data  = buf_q[{idx_q[1:0], 3'b000} +: 8];
                m_last  = last_byte;
                if (m_ready) begin
`ifdef CD_RX_DRAIN_TIMEOUT_EN
                    stall_d = 16'd0;
`endif
                    if (last_byte) begin
                        state_d = REL;
                    end else begin
                        idx_d = idx_q + 8'd1;
                        // No prefetch: each new word costs a W_RD/W_WAIT bubble.
                        if (idx_q[1:0] == 2'd3) state_d = W_RD;
                    end
                end
`ifdef CD_RX_DRAIN_TIMEOUT_EN
                else if (stall_q == TIMEOUT - 16'd1) begin
                    stall_d = 16'd0;
                    abort_d = 1'b1;
                    state_d = REL;
                end else begin
                    stall_d = stall_q + 16'd1;
                end
`endif
            end
            REL: begin
                csr_write     = 1'b1;
                csr_address   = REG_RX_CTRL;
                csr_writedata = 32'd1 << BIT_RD_DONE;
                state_d       = IDLE;
`ifdef CD_RX_DRAIN_TIMEOUT_EN
                if (abort_q) drop_d = drop_q + 16'd1;
                else         frame_d = frame_q + 16'd1;
`else
                frame_d = frame_q + 16'd1;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= 8'd0;
            total_q <= 9'd0;
            buf_q   <= 32'd0;
            frame_q <= 16'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            total_q <= total_d;
            buf_q   <= buf_d;
            frame_q <= frame_d;
        end
    end

`ifdef CD_RX_DRAIN_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= 16'd0;
            drop_q  <= 16'd0;
            abort_q <= 1'b0;
        end else begin
            stall_q <= stall_d;
            drop_q  <= drop_d;
            abort_q <= abort_d;
        end
    end
    assign drop_cnt = drop_q;
`else
    assign drop_cnt = 16'd0;
`endif

    // Only the pending bit of status is meaningful here.
    logic unused_ok;
    assign unused_ok = ^{csr_readdata, TIMEOUT};

endmodule

// File: tb/tb_cd_rx_drain.sv
// Bench for cd_rx_drain: cdbus csr/RX-RAM slave model, byte-queue reference model, table-driven frame scenarios.
module tb_cd_rx_drain;

    logic        clk = 1'b0;
    logic        reset_n, enable, irq, m_ready;
    logic [3:0]  csr_address, csr_byteenable;
    logic        csr_read, csr_write, rx_mm_read;
    logic [31:0] csr_readdata, csr_writedata, rx_mm_readdata;
    logic [5:0]  rx_mm_address;
    logic [7:0]  m_data;
    logic        m_valid, m_last, busy;
    logic [15:0] frame_cnt, drop_cnt;

    cd_rx_drain #(.TIMEOUT(16'd16)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .irq(irq),
        .csr_address(csr_address), .csr_byteenable(csr_byteenable),
        .csr_read(csr_read), .csr_readdata(csr_readdata),
        .csr_write(csr_write), .csr_writedata(csr_writedata),
        .rx_mm_address(rx_mm_address), .rx_mm_read(rx_mm_read), .rx_mm_readdata(rx_mm_readdata),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
        .busy(busy), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    // Pending pages live in a 4-slot ring; the head slot is what RX RAM shows.
    logic [7:0] pages [0:3][0:255];
    int         pages_loaded = 0;
    int         pages_released = 0;
    logic [1:0] cur_slot;
    assign cur_slot = 2'(pages_released);

    always @(posedge clk) begin
        if (csr_read) csr_readdata <= (pages_loaded != pages_released) ? 32'h4 : 32'h0;
        else          csr_readdata <= $urandom;
        if (rx_mm_read)
            rx_mm_readdata <= {pages[cur_slot][{rx_mm_address, 2'd3}], pages[cur_slot][{rx_mm_address, 2'd2}],
                               pages[cur_slot][{rx_mm_address, 2'd1}], pages[cur_slot][{rx_mm_address, 2'd0}]};
        else
            rx_mm_readdata <= $urandom;
        if (csr_write && csr_address == 4'd5 && csr_writedata[0]) pages_released <= pages_released + 1;
    end

    int checks = 0, failures = 0;
    int duty = 100;
    int bytes_seen = 0, csr_reads = 0, csr_writes = 0, rx_reads = 0, stall_cycles = 0, word_exp = 0;
    int frames_exp = 0;
    logic [8:0] exp_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a page yields 3 + min(len,253) bytes, last one flagged.
    task automatic push_expected(input int slot);
        int total;
        total = 3 + ((pages[slot][2] > 8'd253) ? 253 : int'(pages[slot][2]));
        for (int i = 0; i < total; i++) exp_q.push_back({(i == total - 1), pages[slot][i]});
    endtask

    task automatic load_page(input logic [7:0] len);
        int slot;
        slot = pages_loaded % 4;
        for (int i = 0; i < 256; i++) pages[slot][i] = 8'($urandom);
        pages[slot][0] = 8'h01;
        pages[slot][1] = 8'h02;
        pages[slot][2] = len;
        push_expected(slot);
        pages_loaded++;
    endtask

    task automatic wait_drained(input string name);
        int n;
        n = 0;
        irq = 1'b1;
        while (((pages_loaded != pages_released) || busy) && n < 8000) begin @(negedge clk); n++; end
        irq = 1'b0;
        while (busy && n < 8100) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        chk({name, "_drain_timeout"}, (n >= 8000), 0);
    endtask

    task automatic drive_ready();
        int run;
        run = 0;
        forever begin
            @(posedge clk); #1;
            if (duty >= 100)                m_ready = 1'b1;
            else if (duty > 0 && run >= 10) m_ready = 1'b1;
            else                            m_ready = ($urandom_range(0, 99) < duty);
            run = m_ready ? 0 : run + 1;
        end
    endtask

    task automatic monitor();
        logic prev_stall, prev_last, prev_cr, prev_cw, prev_rr;
        logic [7:0] prev_data;
        logic [8:0] e;
        prev_stall = 0; prev_last = 0; prev_data = 0; prev_cr = 0; prev_cw = 0; prev_rr = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_stall = 0; prev_cr = 0; prev_cw = 0; prev_rr = 0;
                continue;
            end
            if (csr_read | csr_write | rx_mm_read) begin
                chk("strobe_onehot", ($countones({csr_read, csr_write, rx_mm_read}) > 1), 0);
                chk("strobe_1cycle", (csr_read & prev_cr) | (csr_write & prev_cw) | (rx_mm_read & prev_rr), 0);
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL extra_byte: got %0h expected no byte", {m_last, m_data});
                end else begin
                    e = exp_q.pop_front();
                    chk("stream_byte", {m_last, m_data}, e);
                end
                bytes_seen++;
            end
            if (prev_stall) begin
`ifndef CD_RX_DRAIN_TIMEOUT_EN
                chk("stall_valid_held", m_valid, 1);
`endif
                if (m_valid) chk("stall_stable", {m_last, m_data}, {prev_last, prev_data});
            end
            if (m_valid && !m_ready) stall_cycles++;
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
            if (rx_mm_read) begin chk("rx_addr", rx_mm_address, word_exp); word_exp++; rx_reads++; end
            if (csr_read)   begin chk("csr_rd_addr", csr_address, 0); csr_reads++; word_exp = 0; end
            if (csr_write)  begin chk("csr_wr", {csr_address, csr_writedata}, {4'd5, 32'h1}); csr_writes++; end
            prev_cr = csr_read; prev_cw = csr_write; prev_rr = rx_mm_read;
        end
    endtask

    typedef struct {
        logic [7:0] len;
        int         duty;
        int         npages;
        int         exp_bytes;
        int         exp_words;
    } vec_t;
    vec_t vecs [10];

    initial begin
        int b0, w0, r0, c0, s0, p0, n;
        vecs[0] = '{8'h03, 100, 1,   6,  2};
        vecs[1] = '{8'hFF, 100, 1, 256, 64};
        vecs[2] = '{8'hFD, 100, 1, 256, 64};
        vecs[3] = '{8'hFC, 100, 1, 255, 64};
        vecs[4] = '{8'h00, 100, 1,   3,  1};
        vecs[5] = '{8'h05,  30, 1,   8,  2};
        vecs[6] = '{8'h40,  30, 1,  67, 17};
        vecs[7] = '{8'h07, 100, 2,  20,  6};
        vecs[8] = '{8'hFF,  30, 1, 256, 64};
        vecs[9] = '{8'h01,  50, 3,  12,  3};

        reset_n = 1'b0; enable = 1'b0; irq = 1'b0; m_ready = 1'b1;
        fork
            monitor();
            drive_ready();
        join_none

        repeat (3) @(posedge clk);
        #1;
        chk("rst_strobes", {csr_read, csr_write, rx_mm_read}, 0);
        chk("rst_stream", {m_valid, m_last, m_data}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_addr", {csr_address, rx_mm_address}, 0);
        chk("rst_counters", {frame_cnt, drop_cnt}, 0);
        chk("rst_byteenable", csr_byteenable, 4'hF);
        @(negedge clk);
        reset_n = 1'b1;
        enable  = 1'b1;
        repeat (2) @(negedge clk);

        // irq with nothing pending: one status read, no RAM access
        c0 = csr_reads; r0 = rx_reads; b0 = bytes_seen;
        irq = 1'b1;
        @(negedge clk);
        irq = 1'b0;
        repeat (10) @(negedge clk);
        chk("nopend_csr_reads", csr_reads - c0, 1);
        chk("nopend_rx_reads", rx_reads - r0, 0);
        chk("nopend_bytes", bytes_seen - b0, 0);
        chk("nopend_busy", busy, 0);
        $display("txn nopend: csr_reads=%0d rx_reads=%0d", csr_reads - c0, rx_reads - r0);

        // enable low holds off a pending page; raising it drains the page
        enable = 1'b0;
        c0 = csr_reads; b0 = bytes_seen;
        load_page(8'h02);
        irq = 1'b1;
        repeat (20) @(negedge clk);
        chk("disabled_csr_reads", csr_reads - c0, 0);
        chk("disabled_busy", busy, 0);
        enable = 1'b1;
        wait_drained("enable");
        frames_exp++;
        chk("enable_bytes", bytes_seen - b0, 5);
        chk("enable_frame_cnt", frame_cnt, frames_exp);
        $display("txn enable: bytes=%0d frame_cnt=%0d", bytes_seen - b0, frame_cnt);

        for (int v = 0; v < 10; v++) begin
            duty = vecs[v].duty;
            b0 = bytes_seen; w0 = csr_writes; r0 = rx_reads;
            for (int p = 0; p < vecs[v].npages; p++) load_page(vecs[v].len);
            wait_drained("vec");
            frames_exp += vecs[v].npages;
            chk("vec_bytes", bytes_seen - b0, vecs[v].exp_bytes);
            chk("vec_words", rx_reads - r0, vecs[v].exp_words);
            chk("vec_rel_writes", csr_writes - w0, vecs[v].npages);
            chk("vec_frame_cnt", frame_cnt, frames_exp);
            chk("vec_queue_empty", exp_q.size(), 0);
            chk("vec_drop_cnt", drop_cnt, 0);
            $display("txn vec%0d: len=%0h duty=%0d pages=%0d bytes=%0d words=%0d frame_cnt=%0d",
                     v, vecs[v].len, duty, vecs[v].npages, bytes_seen - b0, rx_reads - r0, frame_cnt);
        end
        duty = 100;

`ifdef CD_RX_DRAIN_TIMEOUT_EN
        // Sink never ready: abort after TIMEOUT stall cycles, page still released
        duty = 0;
        repeat (2) @(negedge clk);
        b0 = bytes_seen; w0 = csr_writes; s0 = stall_cycles; p0 = pages_released;
        load_page(8'h10);
        irq = 1'b1;
        n = 0;
        while (drop_cnt == 16'd0 && n < 500) begin @(negedge clk); n++; end
        irq = 1'b0;
        repeat (4) @(negedge clk);
        chk("to_wait", (n >= 500), 0);
        chk("to_drop_cnt", drop_cnt, 1);
        chk("to_frame_cnt", frame_cnt, frames_exp);
        chk("to_stall_cycles", stall_cycles - s0, 16);
        chk("to_rel_writes", csr_writes - w0, 1);
        chk("to_released", pages_released - p0, 1);
        chk("to_bytes", bytes_seen - b0, 0);
        exp_q.delete();
        duty = 100;
        repeat (2) @(negedge clk);
        $display("txn timeout: stalls=%0d drop_cnt=%0d", stall_cycles - s0, drop_cnt);
`endif

        // Reset mid-stream: outputs drop at once, the same page drains again afterwards
        b0 = bytes_seen;
        load_page(8'h20);
        irq = 1'b1;
        n = 0;
        while (bytes_seen - b0 < 5 && n < 300) begin @(negedge clk); n++; end
        chk("rst_mid_reach", (n >= 300), 0);
        reset_n = 1'b0;
        irq = 1'b0;
        #1;
        chk("rst_mid_strobes", {csr_read, csr_write, rx_mm_read}, 0);
        chk("rst_mid_stream", {m_valid, m_last, m_data, busy}, 0);
        chk("rst_mid_counters", {frame_cnt, drop_cnt}, 0);
        @(negedge clk);
        exp_q.delete();
        push_expected(int'(cur_slot));
        reset_n = 1'b1;
        b0 = bytes_seen; w0 = csr_writes;
        frames_exp = 0;
        wait_drained("redrain");
        frames_exp++;
        chk("redrain_bytes", bytes_seen - b0, 35);
        chk("redrain_frame_cnt", frame_cnt, frames_exp);
        chk("redrain_writes", csr_writes - w0, 1);
        chk("redrain_queue_empty", exp_q.size(), 0);
        $display("txn reset_redrain: bytes=%0d frame_cnt=%0d", bytes_seen - b0, frame_cnt);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
